count1s_sched: RTL

COUNT1S_SCHED -- requirements
Module: count1s_sched

---
 rtl/count1s_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/count1s_sched.sv
// count1s_sched: four requesters share one popcount unit through a
// round-robin arbiter. Each grant returns the byte's popcount and the
// requester's updated saturating running total.

// Combinational popcount of one byte.
module count1s (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  // Sum the set bits of the byte.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, data_i[i]};
    end
  end

endmodule

module count1s_sched #(
  parameter int TOT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_req,
  input  logic [31:0]      i_data,
  input  logic [3:0]       i_clr,
  output logic [3:0]       o_ack,
  output logic             o_valid,
  output logic [1:0]       o_id,
  output logic [3:0]       o_count,
  output logic [TOT_W-1:0] o_total
);

  logic [3:0]       ack_q, ack_d;
  logic             valid_q, valid_d;
  logic [1:0]       id_q, id_d;
  logic [3:0]       count_q, count_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [TOT_W-1:0] tot_q [4];
  logic [TOT_W-1:0] tot_d [4];

  logic [3:0]       elig;
  logic             gnt_vld;
  logic [1:0]       gnt_id;
  logic [1:0]       cand;
  logic [7:0]       sel_byte;
  logic [3:0]       pop;
  logic [TOT_W-1:0] base;
  logic [TOT_W:0]   sum;
  logic [TOT_W-1:0] new_tot;

  // Round-robin pick starting at the pointer; the requester acked this
  // cycle is masked so it cannot be granted twice for the same byte.
  always_comb begin
    elig    = i_req & ~ack_q;
    gnt_vld = 1'b0;
    gnt_id  = ptr_q;
    cand    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign sel_byte = i_data[{gnt_id, 3'b000} +: 8];

  count1s u_pop (
    .data_i  (sel_byte),
    .count_o (pop)
  );

  // Granted requester's new total: clear takes effect before the add,
  // and the sum sticks at all-ones instead of wrapping.
  always_comb begin
    base    = i_clr[gnt_id] ? '0 : tot_q[gnt_id];
    sum     = {1'b0, base} + {{(TOT_W-3){1'b0}}, pop};
    new_tot = sum[TOT_W] ? '1 : sum[TOT_W-1:0];
  end

  // Next-state for result registers, pointer and per-requester totals.
  always_comb begin
    ack_d   = '0;
    valid_d = gnt_vld;
    id_d    = id_q;
    count_d = count_q;
    total_d = total_q;
    ptr_d   = ptr_q;
    if (gnt_vld) begin
      ack_d   = 4'b0001 << gnt_id;
      id_d    = gnt_id;
      count_d = pop;
      total_d = new_tot;
      ptr_d   = gnt_id + 2'd1;
    end
    for (int k = 0; k < 4; k++) begin
      tot_d[k] = tot_q[k];
      if (gnt_vld && gnt_id == 2'(k)) begin
        tot_d[k] = new_tot;
      end else if (i_clr[k]) begin
        tot_d[k] = '0;
      end
    end
  end

  // State registers; reset drops any grant that was about to register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      count_q <= '0;
      total_q <= '0;
      ptr_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        tot_q[k] <= '0;
      end
    end else begin
      ack_q   <= ack_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      count_q <= count_d;
      total_q <= total_d;
      ptr_q   <= ptr_d;
      for (int k = 0; k < 4; k++) begin
        tot_q[k] <= tot_d[k];
      end
    end
  end

  assign o_ack   = ack_q;
  assign o_valid = valid_q;
  assign o_id    = id_q;
  assign o_count = count_q;
  assign o_total = total_q;

endmodule
